// File: rtl/deinterleaver.sv
// Block deinterleaver: each frame is written in column-read order into one of two ping-pong
// banks and read back in ascending address order. DEINTERLEAVER_SYNC_CHECK_EN adds frame check.
module deinterleaver #(
  parameter int unsigned width = 1,
  parameter int unsigned row   = 512,
  parameter int unsigned col   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
`ifdef DEINTERLEAVER_SYNC_CHECK_EN
  input  logic             s_axis_tlast,
  output logic             frame_err,
`endif
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready
);

  localparam int unsigned N     = row * col;
  localparam int unsigned RowW  = $clog2(row);
  localparam int unsigned ColW  = $clog2(col);
  localparam int unsigned AddrW = $clog2(N);
  localparam logic [RowW-1:0]  RowLast = RowW'(row - 1);
  localparam logic [AddrW-1:0] IdxLast = AddrW'(N - 1);
  localparam logic [AddrW-1:0] ColStep = AddrW'(col);

  typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull} bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];

  logic             ready_en_q;
  logic             wbank_q, wbank_d;
  logic [RowW-1:0]  wrow_q, wrow_d;
  logic [ColW-1:0]  wcol_q, wcol_d;
  logic [AddrW-1:0] widx_q, widx_d;
  logic [AddrW-1:0] waddr_q, waddr_d;

  logic             rbank_q, rbank_d;
  logic [AddrW-1:0] ridx_q, ridx_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic [width-1:0] rd_data_q;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [width-1:0] out_data_q, out_data_d;

  logic in_fire, wlast, rd_issue, rlast, out_ready;

  logic [width-1:0] mem [2**(AddrW+1)];

  assign s_axis_tready = ready_en_q && (bank_q[wbank_q] != BankFull);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign wlast         = (widx_q == IdxLast);
  assign out_ready     = !out_valid_q || m_axis_tready;
  // Issue a read only when the memory-output stage is free or emptying this cycle.
  assign rd_issue      = (bank_q[rbank_q] == BankFull) && (!rd_valid_q || out_ready);
  assign rlast         = (ridx_q == IdxLast);

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;

  // Write address is (k mod row)*col + (k div row), kept incrementally to avoid a multiplier.
  always_comb begin
    wbank_d = wbank_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    widx_d  = widx_q;
    waddr_d = waddr_q;
    if (in_fire) begin
      if (wlast) begin
        wbank_d = ~wbank_q;
        wrow_d  = '0;
        wcol_d  = '0;
        widx_d  = '0;
        waddr_d = '0;
      end else begin
        widx_d = widx_q + 1'b1;
        if (wrow_q == RowLast) begin
          wrow_d  = '0;
          wcol_d  = wcol_q + 1'b1;
          waddr_d = AddrW'(wcol_q) + 1'b1;
        end else begin
          wrow_d  = wrow_q + 1'b1;
          waddr_d = waddr_q + ColStep;
        end
      end
    end
  end

  // A bank is released once its last word has left the memory; the two pipeline registers
  // still hold the tail, so the write side can refill it without a bubble.
  always_comb begin
    bank_d = bank_q;
    if (in_fire) begin
      bank_d[wbank_q] = wlast ? BankFull : BankFilling;
    end
    if (rd_issue && rlast) begin
      bank_d[rbank_q] = BankEmpty;
    end
  end

  always_comb begin
    rbank_d     = rbank_q;
    ridx_d      = ridx_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (rd_issue) begin
      rd_valid_d = 1'b1;
      rd_last_d  = rlast;
      if (rlast) begin
        ridx_d  = '0;
        rbank_d = ~rbank_q;
      end else begin
        ridx_d = ridx_q + 1'b1;
      end
    end else if (out_ready) begin
      rd_valid_d = 1'b0;
    end
    if (out_ready) begin
      out_valid_d = rd_valid_q;
      out_last_d  = rd_valid_q && rd_last_q;
      if (rd_valid_q) begin
        out_data_d = rd_data_q;
      end
    end
  end

  // Read and write never share a bank in the same cycle, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[{wbank_q, waddr_q}] <= s_axis_tdata;
    end
    if (rd_issue) begin
      rd_data_q <= mem[{rbank_q, ridx_q}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= BankEmpty;
      bank_q[1]   <= BankEmpty;
      ready_en_q  <= 1'b0;
      wbank_q     <= 1'b0;
      wrow_q      <= '0;
      wcol_q      <= '0;
      widx_q      <= '0;
      waddr_q     <= '0;
      rbank_q     <= 1'b0;
      ridx_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      ready_en_q  <= 1'b1;
      wbank_q     <= wbank_d;
      wrow_q      <= wrow_d;
      wcol_q      <= wcol_d;
      widx_q      <= widx_d;
      waddr_q     <= waddr_d;
      rbank_q     <= rbank_d;
      ridx_q      <= ridx_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef DEINTERLEAVER_SYNC_CHECK_EN
  logic frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= in_fire && (s_axis_tlast != wlast);
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver (row=4, col=3, width=8): vector table plus scoreboard on
// the output stream, with hand-written stall, reset and frame-check sequences.
module tb_deinterleaver;

  localparam int unsigned W = 8;
  localparam int unsigned R = 4;
  localparam int unsigned C = 3;
  localparam int N = 12;
  localparam int RdyHigh   = 0;
  localparam int RdyLow    = 1;
  localparam int RdyToggle = 2;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       last;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready = 1'b0;
`ifdef DEINTERLEAVER_SYNC_CHECK_EN
  logic       s_tlast = 1'b0;
  logic       frame_err;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = RdyHigh;
  int   stall_cnt = 0;
  int   stall_chk = 0;
  int   perm [N] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
  vec_t vecs [N];
  exp_t exp_q [$];
  exp_t mon_e;
  logic       held_valid = 1'b0;
  logic [7:0] held_data = '0;
  logic       held_last = 1'b0;

  deinterleaver #(
    .width(W),
    .row  (R),
    .col  (C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
`ifdef DEINTERLEAVER_SYNC_CHECK_EN
    .s_axis_tlast (s_tlast),
    .frame_err    (frame_err),
`endif
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec = n_vec + 1;
    if (act != req) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: drives m_tready, checks hold-while-stalled and scoreboards transfers.
  always @(negedge clk) begin
    case (rdy_mode)
      RdyHigh: m_tready = 1'b1;
      RdyLow:  m_tready = 1'b0;
      default: m_tready = ~m_tready;
    endcase
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        stall_chk = stall_chk + 1;
        check("hold_valid", int'(m_tvalid), 1);
        check("hold_data", int'(m_tdata), int'(held_data));
        check("hold_last", int'(m_tlast), int'(held_last));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec = n_vec + 1;
          n_err = n_err + 1;
          $display("FAIL extra_output: got data %0d, required no output", m_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", int'(m_tdata), int'(mon_e.data));
          check("out_last", int'(m_tlast), int'(mon_e.last));
        end
      end
      held_valid = m_tvalid && !m_tready;
      held_data  = m_tdata;
      held_last  = m_tlast;
    end
  end

  task automatic push_frame(input int f);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data = vecs[i].dout + 8'(N * f);
      e.last = vecs[i].last;
      exp_q.push_back(e);
    end
  endtask

  // Called just after a negedge; returns on the negedge following the accepting posedge.
  task automatic send(input logic [7:0] d, input logic tl, input logic exp_err);
    int t = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
`ifdef DEINTERLEAVER_SYNC_CHECK_EN
    s_tlast = tl;
`endif
    if (!s_tready) stall_cnt = stall_cnt + 1;
    while (!s_tready && t < 300) begin
      @(negedge clk);
      t = t + 1;
    end
    if (t >= 300) begin
      check("input_accept_timeout", t, 0);
      s_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
`ifdef DEINTERLEAVER_SYNC_CHECK_EN
    s_tlast = 1'b0;
    check("frame_err", int'(frame_err), int'(exp_err));
`endif
  endtask

  task automatic send_frame(input int f);
    for (int i = 0; i < N; i++) begin
      send(vecs[i].din + 8'(N * f), vecs[i].last, 1'b0);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t = t + 1;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_m_tvalid", int'(m_tvalid), 0);
    check("rst_m_tlast", int'(m_tlast), 0);
    check("rst_m_tdata", int'(m_tdata), 0);
    check("rst_s_tready", int'(s_tready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("s_tready_before_edge", int'(s_tready), 0);
    @(negedge clk);
    check("s_tready_after_edge", int'(s_tready), 1);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < N; i++) begin
      vecs[i].din  = 8'(i);
      vecs[i].dout = 8'(perm[i]);
      vecs[i].last = (i == N - 1);
    end

    // Single frame with latency bound on the first output.
    rdy_mode = RdyHigh;
    do_reset();
    push_frame(0);
    send_frame(0);
    t0 = cyc;
    while (!m_tvalid && (cyc - t0) < 10) @(negedge clk);
    check("first_valid_latency_le2", int'((cyc - t0) <= 2), 1);
    wait_drain();

    // Three back-to-back frames: input must never stall.
    stall_cnt = 0;
    for (int f = 0; f < 3; f++) push_frame(f);
    for (int f = 0; f < 3; f++) send_frame(f);
    check("steady_input_stalls", stall_cnt, 0);
    wait_drain();

    // Output blocked: both banks fill, then input resumes once drained.
    rdy_mode = RdyLow;
    push_frame(0);
    push_frame(1);
    send_frame(0);
    send_frame(1);
    check("s_tready_low_after_23", int'(s_tready), 0);
    repeat (5) @(negedge clk);
    check("s_tready_still_low", int'(s_tready), 0);
    check("no_output_while_blocked", exp_q.size(), 2 * N);
    stall_cnt = 0;
    rdy_mode = RdyHigh;
    for (int i = 0; i < 6; i++) send(8'(24 + i), 1'b0, 1'b0);
    check("resume_had_stall", int'(stall_cnt > 0), 1);
    wait_drain();

    // Toggling downstream ready: hold checks run in the monitor.
    do_reset();
    rdy_mode = RdyToggle;
    stall_chk = 0;
    push_frame(0);
    send_frame(0);
    wait_drain();
    check("stall_cycles_seen", int'(stall_chk > 0), 1);
    rdy_mode = RdyHigh;

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 1'b0, 1'b0);
    do_reset();
    push_frame(0);
    send_frame(0);
    wait_drain();
    repeat (20) @(negedge clk);

`ifdef DEINTERLEAVER_SYNC_CHECK_EN
    // Early tlast on input 10, then a frame missing tlast on input 11.
    push_frame(0);
    for (int i = 0; i < N; i++) send(vecs[i].din, (i >= 10), (i == 10));
    push_frame(0);
    for (int i = 0; i < N; i++) send(vecs[i].din, 1'b0, (i == 11));
    @(negedge clk);
    check("frame_err_cleared", int'(frame_err), 0);
    wait_drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
